instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Writer side of the instruction memory.
- Receives a byte stream from a host or boot link over a valid/ready handshake.
- Packs each group of four bytes into a 32-bit instruction, MSB first.
- Writes each word into a writable 1024x32 instruction RAM, starting at word 0.
- Holds the CPU (cpu_hold) while loading.
- Exposes the RAM to the fetch stage through the same byte-addressed, word-aligned combinational read used by the ROM it replaces.

Parameters:
DEPTH, 1024, number of 32-bit instruction words
ADDR_W, 10, word-index width (log2 DEPTH)
LEN_W, 11, width of load_len (must hold DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset
load_start  input  1  one-cycle request to begin a load
load_len  input  LEN_W  number of words to load, sampled with load_start
byte_valid  input  1  byte_data is valid
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
busy  output  1  load in progress
done  output  1  one-cycle pulse when a load completes
err  output  1  sticky error flag, cleared by the next accepted load_start
cpu_hold  output  1  keep the CPU stalled/reset
fetch_addr  input  32  byte address from PC
fetch_instr  output  32  instruction at word fetch_addr[ADDR_W+1:2]

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; byte_cnt=0; word_cnt=0; shift reg=0.
  - byte_ready=0, busy=0, done=0, err=0, cpu_hold=0.
  - RAM contents are not cleared.
  - Reset mid-load abandons the load; words already written are kept.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - On load_start: clear err.
  - load_len==0: go to DONE, no writes.
  - load_len>DEPTH: clamp length to DEPTH, set err, go to RECV.
  - Otherwise: latch length, go to RECV.
- RECV:
  - byte_ready=1. A byte is accepted when byte_valid&&byte_ready.
  - Each accepted byte: word={word[23:0],byte_data}; byte_cnt++.
  - On the 4th accepted byte go to WRITE; byte_cnt wraps to 0.
- WRITE:
  - byte_ready=0. Write RAM[word_cnt] with the assembled word; word_cnt++.
  - If word_cnt+1==length go to DONE, else go to RECV.
  - Cost: 1 bubble cycle per word, so the minimum is 5 cycles per word.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=cpu_hold=(state!=IDLE), and both are registered.
- load_start while busy is ignored. Bytes offered in IDLE, WRITE or DONE are not accepted.
- Fetch read:
  - Combinational from RAM, index = fetch_addr[ADDR_W+1:2]; fetch_addr[1:0] is ignored.
  - Addresses beyond DEPTH*4 wrap modulo DEPTH.
  - A same-cycle write to the fetched word returns the old data; the new value is visible next cycle.

Optional Feature:
INSTR_LOADER_CHECKSUM_EN:
- Enabled:
  - An 8-bit running sum (mod 256) of all payload bytes is kept.
  - After the last WRITE the FSM enters CHECK instead of DONE and accepts one more byte.
  - If that byte != ~sum+1 (two's complement, so payload+checksum sums to 0), set err.
  - Then go to DONE.
- Disabled: no CHECK state, no trailing byte; err is set only by length clamping.

Decomposition:
- Package instr_loader_pkg:
  - state enum (IDLE, RECV, WRITE, DONE, CHECK);
  - DEPTH/ADDR_W/LEN_W defaults;
  - WORD_BYTES=4.
- Sub-module instr_ram: DEPTH x 32 RAM, synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata).
- The loader FSM and counters live in the top.

Test Plan:
- Load 2 words: load_len=2, bytes 80 01 08 29 80 02 01 09 -> fetch_addr=0 gives 0x80010829; fetch_addr=4 gives 0x80020109; done pulses once; cpu_hold deasserts with done's falling edge.
- byte_valid toggled every other cycle during a 3-word load -> correct words; byte_ready is 0 in each WRITE cycle; no byte lost or duplicated.
- load_len=0 -> done on cycle 2 after load_start, no RAM write, err=0; load_len=1500 -> err=1, exactly 1024 words accepted, then done.
- rst driven low after 6 bytes of a 2-word load -> next cycle busy=0 and byte_ready=0; word 0 is retained; word 1 keeps its previous contents.
- load_start asserted while busy -> ignored, counters unchanged. fetch_addr=0x0000_1003 -> reads word 0 (wrap).
- With INSTR_LOADER_CHECKSUM_EN: payload 80 01 08 29 followed by checksum 0x4E -> err=0; followed by 0x00 -> err=1, done still pulses.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and defaults for the instruction memory loader
//
// Purpose : Loader FSM state encoding and default geometry of the
//           instruction RAM, shared by instr_ram and instr_mem_loader.
// Ports   : none (package)
package instr_loader_pkg;

  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 11;
  localparam int WORD_BYTES = 4;

  // CHECK is reachable only when INSTR_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    CHECK = 3'd4
  } state_t;

endpackage

// File: rtl/instr_ram.sv
// rtl/instr_ram.sv - DEPTH x 32 instruction RAM, sync write, async read
//
// Purpose : Writable instruction store. The read port is combinational so
//           the fetch stage sees it exactly like the ROM it replaces; a
//           write is visible on the read port from the next cycle.
// Ports   : i_clk              clock
//           i_we               write enable
//           i_waddr [ADDR_W]   write word index
//           i_wdata [32]       write data
//           i_raddr [ADDR_W]   read word index
//           o_rdata [32]       read data (combinational)
module instr_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // No reset: contents survive a loader reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream loader for the instruction RAM
//
// Purpose : Accepts bytes over a valid/ready handshake, packs four bytes
//           MSB first into a word and writes consecutive words into the
//           instruction RAM from word 0, holding the CPU while loading.
//           Fetch reads the RAM combinationally by byte address.
// Config  : INSTR_LOADER_CHECKSUM_EN adds a trailing two's-complement
//           checksum byte after the payload; a mismatch sets o_err.
// Ports   : i_clk               clock
//           i_rst               synchronous active-low reset
//           i_load_start        one-cycle load request (ignored while busy)
//           i_load_len [LEN_W]  words to load, sampled with i_load_start
//           i_byte_valid        i_byte_data is valid
//           i_byte_data [8]     stream byte
//           o_byte_ready        byte accepted when valid && ready
//           o_busy              load in progress (registered)
//           o_done              one-cycle completion pulse
//           o_err               sticky error, cleared by next load start
//           o_cpu_hold          keep the CPU stalled (same as o_busy)
//           i_fetch_addr [32]   byte address from the PC
//           o_fetch_instr [32]  instruction at word i_fetch_addr[ADDR_W+1:2]
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_start,
  input  logic [LEN_W-1:0] i_load_len,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte_data,
  output logic             o_byte_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_cpu_hold,
  input  logic [31:0]      i_fetch_addr,
  output logic [31:0]      o_fetch_instr
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_byte_cnt;
  logic [LEN_W-1:0] r_word_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_word_cnt_inc;
  logic [31:0]      r_word;
  logic             r_err;
  logic             r_busy;
  logic             w_byte_ready;
  logic             w_accept;
  logic             w_we;
  logic             w_done;
  logic             w_unused_addr;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]       r_sum;
  logic [7:0]       w_ck_expect;
  assign w_ck_expect = ~r_sum + 8'd1;
`endif

  assign w_accept       = i_byte_valid && w_byte_ready;
  assign w_word_cnt_inc = r_word_cnt + LEN_ONE;

  always_comb begin
    w_next       = r_state;
    w_byte_ready = 1'b0;
    w_we         = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load_start) begin
          w_next = (i_load_len == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        w_byte_ready = 1'b1;
        if (w_accept && (r_byte_cnt == 2'd3)) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        w_we = 1'b1;
        if (w_word_cnt_inc == r_len) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = DONE;
`endif
        end else begin
          w_next = RECV;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHECK: begin
        w_byte_ready = 1'b1;
        if (w_accept) begin
          w_next = DONE;
        end
      end
`endif
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_word     <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state <= w_next;
      // Registered from next state so busy tracks state != IDLE exactly.
      r_busy  <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (i_load_start) begin
            r_err      <= (i_load_len > LEN_MAX);
            r_len      <= (i_load_len > LEN_MAX) ? LEN_MAX : i_load_len;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
          end
        end
        RECV: begin
          if (w_accept) begin
            r_word     <= {r_word[23:0], i_byte_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + i_byte_data;
`endif
          end
        end
        WRITE: r_word_cnt <= w_word_cnt_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
        CHECK: begin
          if (w_accept && (i_byte_data != w_ck_expect)) begin
            r_err <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  instr_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_word_cnt[ADDR_W-1:0]),
    .i_wdata (r_word),
    .i_raddr (i_fetch_addr[ADDR_W+1:2]),
    .o_rdata (o_fetch_instr)
  );

  // Byte offset and upper address bits are ignored: reads wrap modulo DEPTH.
  assign w_unused_addr = ^{i_fetch_addr[31:ADDR_W+2], i_fetch_addr[1:0]};

  assign o_byte_ready = w_byte_ready;
  assign o_busy       = r_busy;
  assign o_cpu_hold   = r_busy;
  assign o_done       = w_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int DEPTH = 1024;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_load_start;
  logic [10:0] i_load_len;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_cpu_hold;
  logic [31:0] i_fetch_addr;
  logic [31:0] o_fetch_instr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [DEPTH];
  logic [7:0]  q [$];

  always #5 i_clk = ~i_clk;

  instr_mem_loader dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_load_start  (i_load_start),
    .i_load_len    (i_load_len),
    .i_byte_valid  (i_byte_valid),
    .i_byte_data   (i_byte_data),
    .o_byte_ready  (o_byte_ready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_cpu_hold    (o_cpu_hold),
    .i_fetch_addr  (i_fetch_addr),
    .o_fetch_instr (o_fetch_instr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic fill_rand(input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic verify_mem(input int n);
    for (int i = 0; i < n; i++) begin
      i_fetch_addr = 32'(i * 4) + 32'($urandom_range(3));
      #1;
      chk($sformatf("fetch[%0d]", i), o_fetch_instr, m_mem[i]);
    end
  endtask

  // mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid
  task automatic do_load(input int len, input int mode, input bit poke,
                         input bit bad_ck, input bit exp_err);
    int eff, npay, total, idx, cyc, dones, bad_bub, done_cyc, budget;
    bit prev4, after_done, v;
    logic [7:0] sum;
    logic [7:0] ck;
    eff  = (len > DEPTH) ? DEPTH : len;
    npay = eff * 4;
    sum  = 8'd0;
    for (int i = 0; i < npay; i++) sum = sum + q[i];
    ck = 8'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (eff > 0) begin
      ck = 8'd0 - sum;
      if (bad_ck) ck = ck + 8'd1;
      q.push_back(ck);
    end
`endif
    total = q.size();
    @(negedge i_clk);
    i_load_start = 1'b1;
    i_load_len   = 11'(len);
    @(negedge i_clk);
    i_load_start = 1'b0;
    idx = 0; cyc = 0; dones = 0; bad_bub = 0; done_cyc = -1;
    prev4 = 1'b0; after_done = 1'b0;
    budget = total * 4 + 40;
    while (cyc < budget) begin
      if (after_done) begin
        chk("hold_release", {31'd0, o_cpu_hold}, 32'd0);
        chk("done_once", {31'd0, o_done}, 32'd0);
        break;
      end
      if (o_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("hold_in_done", {31'd0, o_cpu_hold}, 32'd1);
        after_done = 1'b1;
      end
      if (prev4 && o_byte_ready) bad_bub++;
      i_load_start = poke && (cyc == 3);
      i_load_len   = 11'd1;
      v = (idx < total) && ((mode == 0) || (mode == 1 && cyc % 2 == 0) ||
                            (mode == 2 && $urandom_range(1) == 1));
      i_byte_valid = v;
      i_byte_data  = v ? q[idx] : 8'($urandom);
      prev4 = 1'b0;
      if (v && o_byte_ready) begin
        idx++;
        if (idx % 4 == 0 && idx <= npay) prev4 = 1'b1;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_byte_valid = 1'b0;
    i_load_start = 1'b0;
    chk("in_budget", {31'd0, cyc < budget}, 32'd1);
    chk("accepted", idx, total);
    chk("done_count", dones, 32'd1);
    chk("ready_in_write", bad_bub, 32'd0);
    chk("err", {31'd0, o_err}, {31'd0, exp_err});
    if (len == 0) chk("len0_done_cycle", done_cyc, 32'd0);
    for (int w = 0; w < eff; w++)
      m_mem[w] = {q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]};
  endtask

  initial begin
    int idx, cyc, len;
    i_rst = 1'b0; i_load_start = 1'b0; i_load_len = '0;
    i_byte_valid = 1'b0; i_byte_data = '0; i_fetch_addr = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", {31'd0, o_byte_ready}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_hold", {31'd0, o_cpu_hold}, 32'd0);
    i_rst = 1'b1;

    // Oversized length: clamped to DEPTH words, err set; fills the whole RAM.
    fill_rand(DEPTH * 4);
    do_load(1500, 0, 1'b0, 1'b0, 1'b1);
    verify_mem(DEPTH);

    // Fixed two-word image; err cleared by the new start.
    q = '{8'h80, 8'h01, 8'h08, 8'h29, 8'h80, 8'h02, 8'h01, 8'h09};
    do_load(2, 0, 1'b0, 1'b0, 1'b0);
    i_fetch_addr = 32'd0; #1;
    chk("img_w0", o_fetch_instr, 32'h80010829);
    i_fetch_addr = 32'd4; #1;
    chk("img_w1", o_fetch_instr, 32'h80020109);

    // Valid toggled every other cycle.
    fill_rand(12);
    do_load(3, 1, 1'b0, 1'b0, 1'b0);
    verify_mem(3);

    // Zero length: immediate done, nothing written.
    q.delete();
    do_load(0, 0, 1'b0, 1'b0, 1'b0);
    verify_mem(4);

    // Reset after 6 of 8 bytes: word 0 kept, word 1 untouched.
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    @(negedge i_clk);
    i_load_start = 1'b1; i_load_len = 11'd2;
    @(negedge i_clk);
    i_load_start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 40) begin
      i_byte_valid = 1'b1;
      i_byte_data  = q[idx];
      if (o_byte_ready) idx++;
      @(negedge i_clk);
      cyc++;
    end
    i_byte_valid = 1'b0;
    chk("mid_accepted", idx, 32'd6);
    chk("mid_busy", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_byte_ready}, 32'd0);
    chk("mid_rst_hold", {31'd0, o_cpu_hold}, 32'd0);
    i_rst = 1'b1;
    m_mem[0] = 32'h11223344;
    verify_mem(2);

    // load_start while busy must be ignored.
    fill_rand(16);
    do_load(4, 2, 1'b1, 1'b0, 1'b0);
    verify_mem(4);

    // Address wrap and ignored byte offset.
    i_fetch_addr = 32'h0000_1003; #1;
    chk("wrap_1003", o_fetch_instr, m_mem[0]);
    i_fetch_addr = 32'hFFFF_FFFE; #1;
    chk("wrap_top", o_fetch_instr, m_mem[DEPTH-1]);

    // Random short loads with random valid.
    repeat (6) begin
      len = int'($urandom_range(8, 1));
      fill_rand(len * 4);
      do_load(len, 2, 1'b0, 1'b0, 1'b0);
      verify_mem(len);
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    q = '{8'h80, 8'h01, 8'h08, 8'h29};
    do_load(1, 0, 1'b0, 1'b1, 1'b1);
    q = '{8'h80, 8'h01, 8'h08, 8'h29};
    do_load(1, 0, 1'b0, 1'b0, 1'b0);
    verify_mem(1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
